// File: rtl/axil_bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : axil_bram_pkg
// Brief   : Shared types and constants for the AXI-Lite BRAM arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package axil_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte address bits below this index select a byte within a 32-bit word.
    localparam int WORD_LSB = 2;

    function automatic int word_msb(input int bram_aw);
        return bram_aw + WORD_LSB - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_bram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-requester round-robin arbiter; grant is combinational and the
//          last-grant register only advances when the grant is accepted.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;
    logic w_pick;

    // On contention the port that did not win last time is chosen.
    assign w_pick = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign gnt_o  = (req_i == 2'b00) ? 2'b00 : (w_pick ? 2'b10 : 2'b01);
    assign last_d = accept_i ? w_pick : last_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axil_bram_arbiter
// Brief  : Serialises two AXI-Lite slave ports onto one single-port BRAM.
// Rev    : 1.0 - initial release
// ============================================================================
module axil_bram_arbiter
    import axil_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BRAM_AW    = 10,
    parameter int BRAM_LAT   = 1
) (
    input  logic                  axi_clock,
    input  logic                  axi_resetn,

    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [31:0]           s0_axil_wdata,
    input  logic [3:0]            s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [31:0]           s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,

    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [31:0]           s1_axil_wdata,
    input  logic [3:0]            s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [31:0]           s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,

    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [BRAM_AW-1:0]    bram_addr,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    localparam int         W_MSB = word_msb(BRAM_AW);
    localparam logic [1:0] LAT_C = 2'(BRAM_LAT);

    state_t             state_q;
    logic               port_q;
    logic [1:0]         cnt_q;
    logic               bram_en_q;
    logic [3:0]         bram_we_q;
    logic [BRAM_AW-1:0] bram_addr_q;
    logic [31:0]        bram_din_q;
    logic [1:0]         bvalid_q;
    logic [1:0]         rvalid_q;
    logic [1:0][31:0]   rdata_q;

    logic [1:0]         w_wreq;
    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic [1:0]         w_bready;
    logic [1:0]         w_rready;
    logic               w_idle;
    logic               w_accept;
    logic               w_gidx;
    logic               w_gwrite;
    logic               w_resp_done;
    logic [BRAM_AW-1:0] w_waddr;
    logic [BRAM_AW-1:0] w_raddr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;
    logic               w_unused_addr_bits;

    assign w_wreq   = {s1_axil_awvalid & s1_axil_wvalid, s0_axil_awvalid & s0_axil_wvalid};
    assign w_req    = w_wreq | {s1_axil_arvalid, s0_axil_arvalid};
    assign w_bready = {s1_axil_bready, s0_axil_bready};
    assign w_rready = {s1_axil_rready, s0_axil_rready};

    // Readies are gated by reset so nothing handshakes while the block is held.
    assign w_idle   = (state_q == IDLE) && axi_resetn;
    assign w_accept = w_idle && (w_req != 2'b00);
    assign w_gidx   = w_gnt[1];
    assign w_gwrite = w_wreq[w_gidx];

    assign w_waddr = w_gidx ? s1_axil_awaddr[W_MSB:WORD_LSB] : s0_axil_awaddr[W_MSB:WORD_LSB];
    assign w_raddr = w_gidx ? s1_axil_araddr[W_MSB:WORD_LSB] : s0_axil_araddr[W_MSB:WORD_LSB];
    assign w_wdata = w_gidx ? s1_axil_wdata : s0_axil_wdata;
    assign w_wstrb = w_gidx ? s1_axil_wstrb : s0_axil_wstrb;

    assign w_resp_done = (bvalid_q[port_q] && w_bready[port_q]) ||
                         (rvalid_q[port_q] && w_rready[port_q]);

    assign w_unused_addr_bits = ^{s0_axil_awaddr[ADDR_WIDTH-1:W_MSB+1], s0_axil_awaddr[WORD_LSB-1:0],
                                  s1_axil_awaddr[ADDR_WIDTH-1:W_MSB+1], s1_axil_awaddr[WORD_LSB-1:0],
                                  s0_axil_araddr[ADDR_WIDTH-1:W_MSB+1], s0_axil_araddr[WORD_LSB-1:0],
                                  s1_axil_araddr[ADDR_WIDTH-1:W_MSB+1], s1_axil_araddr[WORD_LSB-1:0]};

    rr_arb2 u_arb (
        .clk_i    (axi_clock),
        .rst_ni   (axi_resetn),
        .req_i    (w_req),
        .accept_i (w_accept),
        .gnt_o    (w_gnt)
    );

    always_ff @(posedge axi_clock) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            cnt_q       <= 2'd0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'h0;
            bram_addr_q <= '0;
            bram_din_q  <= 32'h0;
            bvalid_q    <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        port_q    <= w_gidx;
                        bram_en_q <= 1'b1;
                        cnt_q     <= 2'd0;
                        if (w_gwrite) begin
                            state_q     <= WR;
                            bram_we_q   <= w_wstrb;
                            bram_addr_q <= w_waddr;
                            bram_din_q  <= w_wdata;
                        end else begin
                            state_q     <= RD;
                            bram_we_q   <= 4'h0;
                            bram_addr_q <= w_raddr;
                        end
                    end
                end
                WR: begin
                    bram_en_q        <= 1'b0;
                    bram_we_q        <= 4'h0;
                    bvalid_q[port_q] <= 1'b1;
                    state_q          <= RESP;
                end
                RD: begin
                    bram_en_q <= 1'b0;
                    // cnt_q reaches BRAM_LAT exactly when bram_dout carries the word.
                    if (cnt_q == LAT_C) begin
                        rdata_q[port_q]  <= bram_dout;
                        rvalid_q[port_q] <= 1'b1;
                        state_q          <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        bvalid_q <= 2'b00;
                        rvalid_q <= 2'b00;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0_axil_awready = w_idle & w_gnt[0] & w_wreq[0];
    assign s0_axil_wready  = w_idle & w_gnt[0] & w_wreq[0];
    assign s0_axil_arready = w_idle & w_gnt[0] & ~w_wreq[0];
    assign s1_axil_awready = w_idle & w_gnt[1] & w_wreq[1];
    assign s1_axil_wready  = w_idle & w_gnt[1] & w_wreq[1];
    assign s1_axil_arready = w_idle & w_gnt[1] & ~w_wreq[1];

    assign s0_axil_bvalid = bvalid_q[0];
    assign s1_axil_bvalid = bvalid_q[1];
    assign s0_axil_rvalid = rvalid_q[0];
    assign s1_axil_rvalid = rvalid_q[1];
    assign s0_axil_rdata  = rdata_q[0];
    assign s1_axil_rdata  = rdata_q[1];
    assign s0_axil_bresp  = RESP_OKAY;
    assign s1_axil_bresp  = RESP_OKAY;
    assign s0_axil_rresp  = RESP_OKAY;
    assign s1_axil_rresp  = RESP_OKAY;

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axil_bram_arbiter
// Brief  : Self-checking bench with a BRAM model and a word-level reference.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axil_bram_arbiter;

    localparam int LAT = 1;

    logic        clk;
    logic        rstn;
    logic [31:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [31:0] araddr [2];
    logic [1:0]  awvalid, wvalid, arvalid, bready, rready;

    wire  [1:0]  awready, wready, arready, bvalid, rvalid;
    wire  [1:0]  bresp0, bresp1, rresp0, rresp1;
    wire  [31:0] rdata0, rdata1;
    wire         bram_en;
    wire  [3:0]  bram_we;
    wire  [9:0]  bram_addr;
    wire  [31:0] bram_din;
    wire  [31:0] bram_dout;

    logic [31:0] mem     [1024];
    logic [31:0] pipe    [LAT];
    logic [31:0] ref_mem [1024];
    int          exp_last;
    int          n_checks;
    int          n_errors;

    axil_bram_arbiter #(.ADDR_WIDTH(32), .BRAM_AW(10), .BRAM_LAT(LAT)) dut (
        .axi_clock(clk), .axi_resetn(rstn),
        .s0_axil_awaddr(awaddr[0]), .s0_axil_awvalid(awvalid[0]), .s0_axil_awready(awready[0]),
        .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]), .s0_axil_wvalid(wvalid[0]),
        .s0_axil_wready(wready[0]), .s0_axil_bresp(bresp0), .s0_axil_bvalid(bvalid[0]),
        .s0_axil_bready(bready[0]), .s0_axil_araddr(araddr[0]), .s0_axil_arvalid(arvalid[0]),
        .s0_axil_arready(arready[0]), .s0_axil_rdata(rdata0), .s0_axil_rresp(rresp0),
        .s0_axil_rvalid(rvalid[0]), .s0_axil_rready(rready[0]),
        .s1_axil_awaddr(awaddr[1]), .s1_axil_awvalid(awvalid[1]), .s1_axil_awready(awready[1]),
        .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]), .s1_axil_wvalid(wvalid[1]),
        .s1_axil_wready(wready[1]), .s1_axil_bresp(bresp1), .s1_axil_bvalid(bvalid[1]),
        .s1_axil_bready(bready[1]), .s1_axil_araddr(araddr[1]), .s1_axil_arvalid(arvalid[1]),
        .s1_axil_arready(arready[1]), .s1_axil_rdata(rdata1), .s1_axil_rresp(rresp1),
        .s1_axil_rvalid(rvalid[1]), .s1_axil_rready(rready[1]),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with byte enables and LAT-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            pipe[0] <= mem[bram_addr];
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[LAT-1];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_write(input logic [9:0] idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? rdata1 : rdata0;
    endfunction

    function automatic logic [1:0] resp_of(input int p, input bit wr);
        if (wr) return (p == 1) ? bresp1 : bresp0;
        return (p == 1) ? rresp1 : rresp0;
    endfunction

    // One isolated transaction on port p; response held for `hold` extra cycles.
    task automatic run_txn(input int p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int hold);
        int          o;
        int          lat;
        logic [9:0]  idx;
        logic [31:0] exp_rd;
        o   = 1 - p;
        lat = wr ? 2 : 2 + LAT;
        idx = addr[11:2];
        step();
        if (wr) begin
            awaddr[p] = addr; wdata[p] = data; wstrb[p] = strb;
            awvalid[p] = 1'b1; wvalid[p] = 1'b1;
        end else begin
            araddr[p] = addr; arvalid[p] = 1'b1;
        end
        #1;
        check("awready", 32'(awready[p]), 32'(wr));
        check("wready", 32'(wready[p]), 32'(wr));
        check("arready", 32'(arready[p]), 32'(!wr));
        check("other_ready", 32'({awready[o], wready[o], arready[o]}), 32'd0);
        exp_last = p;
        exp_rd   = ref_mem[idx];
        if (wr) ref_write(idx, data, strb);
        step();
        awvalid[p] = 1'b0; wvalid[p] = 1'b0; arvalid[p] = 1'b0;
        #1;
        check("bram_en", 32'(bram_en), 32'd1);
        check("bram_we", 32'(bram_we), wr ? 32'(strb) : 32'd0);
        check("bram_addr", 32'(bram_addr), 32'(idx));
        if (wr) check("bram_din", bram_din, data);
        for (int c = 2; c < lat; c++) begin
            step(); #1;
            check("early_valid", 32'({bvalid, rvalid}), 32'd0);
            check("bram_en_off", 32'(bram_en), 32'd0);
        end
        step();
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) step();
            if (wr) bready[p] = (h == hold); else rready[p] = (h == hold);
            arvalid[o] = (h < hold);
            #1;
            check(wr ? "bvalid" : "rvalid", 32'(wr ? bvalid[p] : rvalid[p]), 32'd1);
            check("stray_valid", 32'({bvalid[o], rvalid[o], wr ? rvalid[p] : bvalid[p]}), 32'd0);
            if (!wr) check("rdata", rdata_of(p), exp_rd);
            check("resp", 32'(resp_of(p, wr)), 32'd0);
            check("busy_ready", 32'({arready, awready, wready}), 32'd0);
        end
        step();
        bready[p] = 1'b0; rready[p] = 1'b0; arvalid[o] = 1'b0;
        #1;
        check("valid_clear", 32'({bvalid, rvalid}), 32'd0);
    endtask

    task automatic contention(input int n_txn);
        int          win;
        int          pred;
        logic [9:0]  idx;
        step();
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = 32'(200 + p) << 2;
            wdata[p]  = $urandom();
            wstrb[p]  = 4'hF;
        end
        awvalid = 2'b11; wvalid = 2'b11; bready = 2'b11;
        #1;
        for (int k = 0; k < n_txn; k++) begin
            win  = -1;
            pred = (exp_last == 0) ? 1 : 0;
            for (int c = 0; c < 8; c++) begin
                if (awready != 2'b00) begin
                    win = awready[1] ? 1 : 0;
                    break;
                end
                step(); #1;
            end
            if (win < 0) begin
                check("grant_timeout", 32'd0, 32'd1);
                break;
            end
            check("grant_vec", 32'(awready), 32'(1) << pred);
            check("grant_wready", 32'(wready), 32'(awready));
            idx = awaddr[win][11:2];
            ref_write(idx, wdata[win], wstrb[win]);
            exp_last = win;
            step();
            wdata[win] = $urandom();
            #1;
            check("busy_ready_c", 32'({awready, wready, arready}), 32'd0);
            check("early_bvalid", 32'(bvalid), 32'd0);
            step(); #1;
            check("bvalid_port", 32'(bvalid), 32'(1) << win);
            step(); #1;
        end
        awvalid = 2'b00; wvalid = 2'b00; bready = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_last = 1;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = 32'h0; wdata[p] = 32'h0; wstrb[p] = 4'h0; araddr[p] = 32'h0;
        end
        awvalid = 2'b00; wvalid = 2'b10; arvalid = 2'b01; bready = 2'b00; rready = 2'b00;
        awvalid[1] = 1'b1;
        rstn = 1'b0;

        // Reset with requests present: nothing may handshake.
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_bram", 32'({bram_en, bram_we}), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_din", bram_din, 32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'd0);
        check("rst_resp", 32'({bresp0, bresp1, rresp0, rresp1}), 32'd0);
        step();
        rstn = 1'b1; awvalid = 2'b00; wvalid = 2'b00; arvalid = 2'b00;

        run_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
        run_txn(1, 1'b0, 32'hFFFF_F013, 32'h0, 4'h0, 5);
        run_txn(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0101, 2);
        run_txn(0, 1'b0, 32'h8000_1012, 32'h0, 4'h0, 1);

        contention(4);
        run_txn(0, 1'b0, 32'd200 << 2, 32'h0, 4'h0, 0);
        run_txn(1, 1'b0, 32'd201 << 2, 32'h0, 4'h0, 0);

        // Same port presents a write and a read together: write first.
        step();
        awaddr[1] = 32'h0000_0FFC; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF;
        araddr[1] = 32'h0000_0FFC;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1; arvalid[1] = 1'b1; bready[1] = 1'b1; rready[1] = 1'b1;
        #1;
        check("wr_first_aw", 32'(awready[1]), 32'd1);
        check("wr_first_ar", 32'(arready[1]), 32'd0);
        ref_write(10'h3FF, 32'hCAFE_F00D, 4'hF);
        exp_last = 1;
        step(); awvalid[1] = 1'b0; wvalid[1] = 1'b0; #1;
        check("pend_ar_busy", 32'(arready[1]), 32'd0);
        step(); #1;
        check("pend_bvalid", 32'(bvalid[1]), 32'd1);
        check("pend_ar_resp", 32'(arready[1]), 32'd0);
        step(); #1;
        check("pend_ar_grant", 32'(arready[1]), 32'd1);
        step(); arvalid[1] = 1'b0; #1;
        check("pend_rd_addr", 32'(bram_addr), 32'h3FF);
        step(); #1;
        check("pend_rvalid_early", 32'(rvalid[1]), 32'd0);
        step(); #1;
        check("pend_rvalid", 32'(rvalid[1]), 32'd1);
        check("pend_rdata", rdata1, ref_mem[10'h3FF]);
        step(); bready[1] = 1'b0; rready[1] = 1'b0; #1;

        // Reset while a read is in the RD state.
        step();
        araddr[0] = 32'h0000_0010; arvalid[0] = 1'b1; rready[0] = 1'b1;
        #1;
        check("rdrst_arready", 32'(arready[0]), 32'd1);
        step(); arvalid[0] = 1'b0; rstn = 1'b0; #1;
        check("rdrst_in_rd", 32'(bram_en), 32'd1);
        step();
        rstn = 1'b1;
        araddr[0] = 32'h0000_0010; araddr[1] = 32'd200 << 2;
        arvalid = 2'b11; rready = 2'b11;
        #1;
        check("rdrst_valid", 32'({bvalid, rvalid, bram_en}), 32'd0);
        check("rdrst_grant0", 32'(arready), 32'd1);
        exp_last = 0;
        step(); arvalid = 2'b00; #1;
        check("rdrst_en", 32'(bram_en), 32'd1);
        step(); #1;
        check("rdrst_no_stale", 32'(rvalid), 32'd0);
        step(); #1;
        check("rdrst_rvalid", 32'(rvalid), 32'd1);
        check("rdrst_rdata", rdata0, ref_mem[4]);
        step(); rready = 2'b00; #1;

        // Randomised single-port traffic over a small address window.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] r;
            logic [9:0]  idx;
            r   = $urandom();
            idx = ($urandom_range(0, 8) == 8) ? 10'h3FF : 10'($urandom_range(0, 7));
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {r[31:12], idx, r[1:0]}, $urandom(), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_bram_arbiter.md
Name: axil_bram_arbiter

Overview:
- Shares one single-port BRAM (32-bit words, byte-write) between the two PS AXI-Lite masters, M00 and M01, which arrive as slave ports s0 and s1.
- Sits in the PL next to the system wrapper and runs on axi_clock.
- Serialises all accesses: one transaction is in flight at a time.
- Arbitrates round-robin between the ports; within a port, a write takes priority over a read.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite byte-address width.
- BRAM_AW, 10, BRAM word-address width (DEPTH = 2**BRAM_AW).
- BRAM_LAT, 1, BRAM read latency in cycles, from bram_en to valid bram_dout (range 1..3).

Ports:
- axi_clock  in  1  clock for all logic.
- axi_resetn  in  1  synchronous, active-low reset.
- s{0,1}_axil_awaddr  in  ADDR_WIDTH  write address.
- s{0,1}_axil_awvalid / awready  in / out  1  write-address handshake.
- s{0,1}_axil_wdata  in  32  write data.
- s{0,1}_axil_wstrb  in  4  byte strobes.
- s{0,1}_axil_wvalid / wready  in / out  1  write-data handshake.
- s{0,1}_axil_bresp  out  2  write response, always 2'b00 (OKAY).
- s{0,1}_axil_bvalid / bready  out / in  1  write-response handshake.
- s{0,1}_axil_araddr  in  ADDR_WIDTH  read address.
- s{0,1}_axil_arvalid / arready  in / out  1  read-address handshake.
- s{0,1}_axil_rdata  out  32  read data.
- s{0,1}_axil_rresp  out  2  read response, always 2'b00 (OKAY).
- s{0,1}_axil_rvalid / rready  out / in  1  read-data handshake.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  BRAM_AW  BRAM word address.
- bram_din  out  32  BRAM write data.
- bram_dout  in  32  BRAM read data.

Behaviour:
- Reset (axi_resetn=0 at a clock edge):
  - All ready/valid outputs 0; bram_en=0, bram_we=0; bram_addr, bram_din, rdata, resp outputs 0.
  - FSM goes to IDLE; last_grant=1, so port 0 wins first.
  - A reset mid-transaction drops any pending response and aborts any BRAM access. No partial state survives.
- Request per port p:
  - wreq_p = awvalid_p & wvalid_p (AW and W must both be present).
  - rreq_p = arvalid_p.
  - req_p = wreq_p | rreq_p. The port's op is write if wreq_p, else read.
- Arbitration (IDLE only):
  - If req_0 & req_1, grant the port != last_grant; otherwise grant the single requester.
  - On grant: last_grant <= granted port.
- FSM states IDLE, WR, RD, RESP:
  - IDLE, grant write, cycle T: awready_p and wready_p high for exactly cycle T. Latch addr[BRAM_AW+1:2], wdata, wstrb. Go to WR.
  - IDLE, grant read, cycle T: arready_p high for cycle T. Latch address. Go to RD.
  - WR (T+1): bram_en=1, bram_we=latched wstrb. Go to RESP with bvalid_p=1 from T+2.
  - RD: bram_en=1 for one cycle (T+1), we=0. Counter waits BRAM_LAT cycles, then captures bram_dout into rdata_p. rvalid_p=1 from T+2+BRAM_LAT.
  - RESP: hold valid and data stable until the matching ready, then return to IDLE in the next cycle. The earliest next grant is the cycle after the ready handshake.
- Readiness: all awready/wready/arready are 0 outside IDLE, so no second request is accepted while busy.
- Width and address rules:
  - Upper address bits above BRAM_AW+1 and addr[1:0] are ignored; addresses wrap modulo DEPTH.
  - There are no error responses.
  - wstrb=0 still performs the WR cycle (bram_we=0) and returns OKAY.
- Simultaneous events:
  - A write and a read on the same port: the write goes first; the read stays pending, since arready stays low.
  - AW without W (or W without AW): not a request; the block waits.
- Throughput: write = 3 cycles minimum per transaction; read = 3+BRAM_LAT cycles.

Decomposition:
- Package axil_bram_pkg holds:
  - state enum {IDLE, WR, RD, RESP};
  - RESP_OKAY=2'b00;
  - word-address slice constants.
- Natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a last_grant register, combinational grant and an update-on-accept input.

Test Plan:
- Reset, then s0 writes 0xDEADBEEF to 0x10, wstrb=4'hF -> awready/wready pulse at T; bram_en=1, bram_we=F, bram_addr=4, bram_din=0xDEADBEEF at T+1; bvalid=1, bresp=0 at T+2.
- s0 reads 0x10 with BRAM_LAT=1 -> arready at T; bram_en at T+1 with addr 4; rvalid at T+3 with rdata=0xDEADBEEF.
- s0 and s1 both assert write requests every cycle for 4 transactions -> grants alternate 0,1,0,1; each bvalid appears only on the granted port.
- s1 presents AW, W and AR together -> the write completes first, then the read returns the newly written data.
- Hold rready low for 5 cycles -> rvalid and rdata stay stable; no arready or awready on either port until the handshake completes.
- Assert axi_resetn=0 in the RD state -> next cycle all valids are 0 and the FSM is in IDLE; after release, port 0 is granted first.
